// File: rtl/spi_img_pkg.sv
// Shared opcodes, FSM state encoding and status-byte bit positions for spi_image_loader.
package spi_img_pkg;

    localparam logic [7:0] OP_IMG_LOAD   = 8'hA0;
    localparam logic [7:0] OP_CLEAR      = 8'hB0;
    localparam logic [7:0] OP_GET_RESULT = 8'hC0;
    localparam logic [7:0] OP_GET_STATUS = 8'hD0;
    localparam logic [7:0] OP_NOP        = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_START,
        S_WAIT
    } state_e;

    localparam int unsigned ST_BUSY      = 7;
    localparam int unsigned ST_RES_VALID = 6;
    localparam int unsigned ST_ERR_CMD   = 5;
    localparam int unsigned ST_ERR_BUSY  = 4;
    localparam int unsigned ST_ERR_ABORT = 3;
    localparam int unsigned ST_ERR_CHK   = 2;

endpackage

// File: rtl/spi_image_loader_if.sv
// Byte stream to/from the SPI peripheral plus image/result hand-off to the BNN core.
// master: peripheral/BNN side; slave: the loader.
interface spi_image_loader_if #(
    parameter int unsigned IMG_W = 32,
    parameter int unsigned IMG_H = 32,
    parameter int unsigned RES_W = 4
);
    logic [7:0]             rx_byte;
    logic                   byte_valid;
    logic                   spi_error;
    logic [7:0]             tx_byte;
    logic                   byte_ready;
    logic                   rx_enable;
    logic                   tx_enable;
    logic [IMG_W*IMG_H-1:0] img_data;
    logic                   img_start;
    logic                   bnn_busy;
    logic [RES_W-1:0]       bnn_result;
    logic                   bnn_result_valid;

    modport master (
        output rx_byte, byte_valid, spi_error, bnn_busy, bnn_result, bnn_result_valid,
        input  tx_byte, byte_ready, rx_enable, tx_enable, img_data, img_start
    );

    modport slave (
        input  rx_byte, byte_valid, spi_error, bnn_busy, bnn_result, bnn_result_valid,
        output tx_byte, byte_ready, rx_enable, tx_enable, img_data, img_start
    );
endinterface

// File: rtl/image_buffer.sv
// IMG_BYTES x 8 image store with one write port and synchronous clear.
// Flat output: pixel 8k+i is bit (7-i) of byte k, so each byte is laid out MSB first.
module image_buffer #(
    parameter int unsigned IMG_BYTES = 128,
    localparam int unsigned AW = $clog2(IMG_BYTES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   we,
    input  logic [AW-1:0]          addr,
    input  logic [7:0]             wdata,
    output logic [IMG_BYTES*8-1:0] img_data
);

    logic [7:0] mem_q [IMG_BYTES];
    logic [7:0] mem_d [IMG_BYTES];

    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int i = 0; i < IMG_BYTES; i++) mem_d[i] = 8'h00;
        end else if (we) begin
            mem_d[addr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '{default: 8'h00};
        else     mem_q <= mem_d;
    end

    always_comb begin
        img_data = '0;
        for (int k = 0; k < IMG_BYTES; k++) begin
            for (int i = 0; i < 8; i++) img_data[8*k+i] = mem_q[k][7-i];
        end
    end

endmodule

// File: rtl/spi_image_loader.sv
// Command decoder / image assembler between the SPI peripheral and the BNN core.
// Optional trailing XOR checksum byte enabled by defining SPI_IMG_CHECKSUM_EN.
module spi_image_loader
    import spi_img_pkg::*;
#(
    parameter int unsigned IMG_W = 32,
    parameter int unsigned IMG_H = 32,
    parameter int unsigned RES_W = 4,
    localparam int unsigned IMG_BYTES = IMG_W * IMG_H / 8,
    localparam int unsigned CNT_W = $clog2(IMG_BYTES + 1),
    localparam int unsigned AW = $clog2(IMG_BYTES)
) (
    input logic               clk,
    input logic               rst,
    spi_image_loader_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]       tx_q, tx_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             rv_q, rv_d;
    logic             err_cmd_q, err_cmd_d;
    logic             err_busy_q, err_busy_d;
    logic             err_abort_q, err_abort_d;
    logic             err_chk;
    logic             byte_valid_q;
    logic             en_q;
    logic             byte_evt;
    logic             buf_we, buf_clr;
    logic [7:0]       status, result_byte;

`ifdef SPI_IMG_CHECKSUM_EN
    logic [7:0] chk_acc_q, chk_acc_d;
    logic       err_chk_q, err_chk_d;
    assign err_chk = err_chk_q;
`else
    assign err_chk = 1'b0;
`endif

    // byte_valid is a level held for the whole byte; act only on its rising edge
    assign byte_evt = bus.byte_valid & ~byte_valid_q;

    always_comb begin
        status               = 8'h00;
        status[ST_BUSY]      = (state_q != S_IDLE) | bus.bnn_busy;
        status[ST_RES_VALID] = rv_q;
        status[ST_ERR_CMD]   = err_cmd_q;
        status[ST_ERR_BUSY]  = err_busy_q;
        status[ST_ERR_ABORT] = err_abort_q;
        status[ST_ERR_CHK]   = err_chk;
        result_byte              = 8'h00;
        result_byte[7]           = rv_q;
        result_byte[RES_W-1:0]   = result_q;
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        tx_d        = tx_q;
        result_d    = result_q;
        rv_d        = rv_q;
        err_cmd_d   = err_cmd_q;
        err_busy_d  = err_busy_q;
        err_abort_d = err_abort_q;
        buf_we      = 1'b0;
        buf_clr     = 1'b0;
`ifdef SPI_IMG_CHECKSUM_EN
        chk_acc_d = chk_acc_q;
        err_chk_d = err_chk_q;
`endif

        // Commands are decoded while idle and while waiting on the BNN
        if (byte_evt && (state_q == S_IDLE || state_q == S_WAIT)) begin
            case (bus.rx_byte)
                OP_IMG_LOAD: begin
                    if (state_q == S_IDLE) begin
                        state_d    = S_LOAD;
                        byte_cnt_d = '0;
`ifdef SPI_IMG_CHECKSUM_EN
                        chk_acc_d = 8'h00;
`endif
                    end else begin
                        err_busy_d = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    if (state_q == S_IDLE) begin
                        buf_clr     = 1'b1;
                        rv_d        = 1'b0;
                        err_cmd_d   = 1'b0;
                        err_busy_d  = 1'b0;
                        err_abort_d = 1'b0;
`ifdef SPI_IMG_CHECKSUM_EN
                        err_chk_d = 1'b0;
`endif
                    end else begin
                        err_busy_d = 1'b1;
                    end
                end
                OP_GET_RESULT: tx_d = result_byte;
                OP_GET_STATUS: tx_d = status;
                OP_NOP:        ;
                default:       err_cmd_d = 1'b1;
            endcase
        end

        case (state_q)
            S_LOAD: begin
                if (bus.spi_error) begin
                    err_abort_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (byte_evt) begin
                    buf_we     = 1'b1;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
`ifdef SPI_IMG_CHECKSUM_EN
                    chk_acc_d = chk_acc_q ^ bus.rx_byte;
                    if (byte_cnt_q == CNT_W'(IMG_BYTES - 1)) state_d = S_CHECK;
`else
                    if (byte_cnt_q == CNT_W'(IMG_BYTES - 1)) state_d = S_START;
`endif
                end
            end
`ifdef SPI_IMG_CHECKSUM_EN
            S_CHECK: begin
                if (bus.spi_error) begin
                    err_abort_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (byte_evt) begin
                    if (bus.rx_byte == chk_acc_q) begin
                        state_d = S_START;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
`endif
            S_START: begin
                rv_d    = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.bnn_result_valid) begin
                    result_d = bus.bnn_result;
                    rv_d     = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            tx_q         <= 8'h00;
            result_q     <= '0;
            rv_q         <= 1'b0;
            err_cmd_q    <= 1'b0;
            err_busy_q   <= 1'b0;
            err_abort_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            tx_q         <= tx_d;
            result_q     <= result_d;
            rv_q         <= rv_d;
            err_cmd_q    <= err_cmd_d;
            err_busy_q   <= err_busy_d;
            err_abort_q  <= err_abort_d;
            byte_valid_q <= bus.byte_valid;
            en_q         <= 1'b1;
        end
    end

`ifdef SPI_IMG_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_acc_q <= 8'h00;
            err_chk_q <= 1'b0;
        end else begin
            chk_acc_q <= chk_acc_d;
            err_chk_q <= err_chk_d;
        end
    end
`endif

    image_buffer #(
        .IMG_BYTES(IMG_BYTES)
    ) u_image_buffer (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .we      (buf_we),
        .addr    (byte_cnt_q[AW-1:0]),
        .wdata   (bus.rx_byte),
        .img_data(bus.img_data)
    );

    assign bus.tx_byte    = tx_q;
    assign bus.byte_ready = en_q;
    assign bus.rx_enable  = en_q;
    assign bus.tx_enable  = en_q;
    assign bus.img_start  = (state_q == S_START);

endmodule

// File: tb/tb_spi_image_loader.sv
// Randomised scoreboard bench for spi_image_loader; directed scenarios first, then random commands.
`timescale 1ns/1ps
module tb_spi_image_loader;
    import spi_img_pkg::*;

    localparam int unsigned IMG_W     = 32;
    localparam int unsigned IMG_H     = 32;
    localparam int unsigned RES_W     = 4;
    localparam int unsigned IMG_BYTES = IMG_W * IMG_H / 8;
    localparam int unsigned NPIX      = IMG_W * IMG_H;
`ifdef SPI_IMG_CHECKSUM_EN
    localparam int unsigned CHK = 1;
`else
    localparam int unsigned CHK = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_image_loader_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .RES_W(RES_W)) bus ();

    spi_image_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .RES_W(RES_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0]       m_img [IMG_BYTES];
    logic [7:0]       pay   [IMG_BYTES];
    bit               m_wait, m_rv, m_err_cmd, m_err_busy, m_err_abort, m_err_chk;
    logic [RES_W-1:0] m_res;
    bit               busy_in;
    int               exp_starts = 0;
    int               seen_starts = 0;

    bit               is_qry_q [$];
    logic [7:0]       exp_tx_q [$];
    logic [NPIX-1:0]  exp_img_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_img(input string name, input logic [NPIX-1:0] act,
                             input logic [NPIX-1:0] exp);
        int first, ndiff;
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            first = -1;
            ndiff = 0;
            for (int p = 0; p < NPIX; p++) begin
                if (act[p] !== exp[p]) begin
                    if (first < 0) first = p;
                    ndiff++;
                end
            end
            $display("FAIL %s: pixel %0d got %0b, required %0b (%0d pixels differ)",
                     name, first, act[first], exp[first], ndiff);
        end
    endtask

    function automatic logic [NPIX-1:0] flat_img();
        logic [NPIX-1:0] v;
        for (int p = 0; p < NPIX; p++) v[p] = m_img[p / 8][7 - (p % 8)];
        return v;
    endfunction

    function automatic logic [7:0] m_status();
        return {m_wait | busy_in, m_rv, m_err_cmd, m_err_busy, m_err_abort, m_err_chk, 2'b00};
    endfunction

    function automatic logic [7:0] m_result();
        return {m_rv, 3'b000, m_res};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < IMG_BYTES; k++) m_img[k] = 8'h00;
        m_rv = 0; m_err_cmd = 0; m_err_busy = 0; m_err_abort = 0; m_err_chk = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_qry, input logic [7:0] exp);
        is_qry_q.push_back(is_qry);
        if (is_qry) exp_tx_q.push_back(exp);
        @(posedge clk); #1;
        bus.rx_byte    = b;
        bus.byte_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.byte_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic q_status();
        send_byte(OP_GET_STATUS, 1, m_status());
    endtask

    task automatic q_result();
        send_byte(OP_GET_RESULT, 1, m_result());
    endtask

    task automatic pulse_result(input logic [RES_W-1:0] r);
        @(posedge clk); #1;
        bus.bnn_result       = r;
        bus.bnn_result_valid = 1'b1;
        @(posedge clk); #1;
        bus.bnn_result_valid = 1'b0;
        busy_in              = 0;
        bus.bnn_busy         = 1'b0;
        if (m_wait) begin
            m_wait = 0;
            m_rv   = 1;
            m_res  = r;
        end
    endtask

    task automatic spi_abort();
        @(posedge clk); #1 bus.spi_error = 1'b1;
        @(posedge clk); #1 bus.spi_error = 1'b0;
        m_err_abort = 1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.byte_valid = 1'b0; bus.spi_error = 1'b0; bus.bnn_result_valid = 1'b0;
        busy_in = 0; bus.bnn_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_byte_ready", bus.byte_ready, 0);
        check("rst_rx_enable", bus.rx_enable, 0);
        check("rst_tx_byte", bus.tx_byte, 8'h00);
        check("rst_img_start", bus.img_start, 0);
        check_img("rst_img_data", bus.img_data, '0);
        @(posedge clk); #1 rst = 1'b0;
        model_clear();
        m_wait = 0; m_res = '0;
        @(negedge clk);
        check("release_byte_ready_early", bus.byte_ready, 0);
        @(negedge clk);
        check("release_byte_ready", bus.byte_ready, 1);
        check("release_rx_enable", bus.rx_enable, 1);
        check("release_tx_enable", bus.tx_enable, 1);
    endtask

    // Full IMG_LOAD transaction through to a latched BNN result
    task automatic do_full_load(input bit bad_chk, input bit busy_err, input logic [RES_W-1:0] res);
        logic [7:0] x;
        x = 8'h00;
        send_byte(OP_IMG_LOAD, 0, 8'h00);
        for (int k = 0; k < IMG_BYTES; k++) begin
            m_img[k] = pay[k];
            x ^= pay[k];
            if (CHK == 0 && k == IMG_BYTES - 1) begin
                exp_img_q.push_back(flat_img());
                exp_starts++;
            end
            send_byte(pay[k], 0, 8'h00);
        end
        if (CHK != 0) begin
            if (bad_chk) begin
                m_err_chk = 1;
                send_byte(x ^ 8'h01, 0, 8'h00);
                check("no_start_bad_chk", seen_starts, exp_starts);
                return;
            end
            exp_img_q.push_back(flat_img());
            exp_starts++;
            send_byte(x, 0, 8'h00);
        end
        check("img_start_count", seen_starts, exp_starts);
        m_wait = 1;
        m_rv   = 0;
        busy_in = 1'($urandom_range(0, 1));
        bus.bnn_busy = busy_in;
        q_status();
        if (busy_err) begin
            send_byte(OP_IMG_LOAD, 0, 8'h00);
            m_err_busy = 1;
            q_status();
        end
        pulse_result(res);
        q_result();
    endtask

    task automatic do_abort(input int n);
        send_byte(OP_IMG_LOAD, 0, 8'h00);
        for (int k = 0; k < n; k++) begin
            pay[k] = 8'($urandom);
            m_img[k] = pay[k];
            send_byte(pay[k], 0, 8'h00);
        end
        spi_abort();
        check_img("img_after_abort", bus.img_data, flat_img());
        check("no_start_abort", seen_starts, exp_starts);
    endtask

    // tx_byte monitor: a query byte's answer appears one cycle after its byte event
    initial begin : mon_tx
        bit prev_bv;
        bit q;
        logic [7:0] e;
        prev_bv = 0;
        forever begin
            @(negedge clk);
            if (bus.byte_valid === 1'b1 && !prev_bv) begin
                if (is_qry_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL byte_scoreboard: byte seen with no entry queued");
                end else begin
                    q = is_qry_q.pop_front();
                    if (q) begin
                        e = exp_tx_q.pop_front();
                        @(negedge clk);
                        check("tx_byte", bus.tx_byte, e);
                    end
                end
            end
            prev_bv = (bus.byte_valid === 1'b1);
        end
    end

    // img_start monitor: every pulse must be expected, single-cycle, with the expected image
    initial begin : mon_start
        bit prev_st;
        prev_st = 0;
        forever begin
            @(negedge clk);
            if (bus.img_start === 1'b1) begin
                if (prev_st) begin
                    n_cmp++; n_bad++;
                    $display("FAIL img_start_width: got pulse longer than 1 cycle, required 1");
                end else begin
                    seen_starts++;
                    if (exp_img_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL img_start_unexpected: got pulse, required none");
                    end else begin
                        check_img("img_at_start", bus.img_data, exp_img_q.pop_front());
                    end
                end
            end
            prev_st = (bus.img_start === 1'b1);
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int op, n;
        logic [7:0] b;
        bus.rx_byte = 8'h00; bus.bnn_result = '0;
        apply_reset();
        repeat (20) @(posedge clk);
        check("idle_no_start", seen_starts, 0);

        // Counting payload, result 7, IMG_LOAD rejected while waiting
        for (int k = 0; k < IMG_BYTES; k++) pay[k] = 8'(k + 1);
        do_full_load(0, 1, 4'd7);
        check_img("img_counting", bus.img_data, flat_img());

        send_byte(OP_CLEAR, 0, 8'h00); model_clear();
        do_abort(40);
        q_status();

        send_byte(8'h55, 0, 8'h00); m_err_cmd = 1;
        q_status();
        send_byte(OP_CLEAR, 0, 8'h00); model_clear();
        q_status();
        check_img("img_after_clear", bus.img_data, '0);

        // A result pulse outside the wait state is ignored
        pulse_result(4'd3);
        q_result();

        if (CHK != 0) begin
            for (int k = 0; k < IMG_BYTES; k++) pay[k] = 8'hFF;
            do_full_load(0, 0, 4'd2);
            send_byte(OP_CLEAR, 0, 8'h00); model_clear();
            do_full_load(1, 0, 4'd0);
            q_status();
        end

        // Reset mid-load: no start, everything back to reset values
        send_byte(OP_IMG_LOAD, 0, 8'h00);
        for (int k = 0; k < 20; k++) send_byte(8'($urandom), 0, 8'h00);
        apply_reset();
        q_status();
        check("no_start_after_reset", seen_starts, exp_starts);

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 6);
            case (op)
                0: begin
                    for (int k = 0; k < IMG_BYTES; k++) pay[k] = 8'($urandom);
                    do_full_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                 RES_W'($urandom));
                end
                1: begin
                    send_byte(OP_CLEAR, 0, 8'h00); model_clear();
                    check_img("img_rand_clear", bus.img_data, '0);
                end
                2: q_status();
                3: q_result();
                4: send_byte(OP_NOP, 0, 8'h00);
                5: begin
                    do b = 8'($urandom);
                    while (b == OP_IMG_LOAD || b == OP_CLEAR || b == OP_GET_RESULT ||
                           b == OP_GET_STATUS || b == OP_NOP);
                    send_byte(b, 0, 8'h00);
                    m_err_cmd = 1;
                end
                default: begin
                    n = $urandom_range(0, IMG_BYTES - 1 + CHK);
                    if (n == IMG_BYTES) begin
                        send_byte(OP_IMG_LOAD, 0, 8'h00);
                        for (int k = 0; k < IMG_BYTES; k++) begin
                            m_img[k] = 8'($urandom);
                            send_byte(m_img[k], 0, 8'h00);
                        end
                        spi_abort();
                        check_img("img_abort_in_check", bus.img_data, flat_img());
                    end else begin
                        do_abort(n);
                    end
                end
            endcase
        end
        q_status();
        q_result();

        repeat (10) @(posedge clk);
        check("final_start_count", seen_starts, exp_starts);
        check("final_tx_queue_empty", exp_tx_q.size(), 0);
        check("final_img_queue_empty", exp_img_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
